// File: rtl/pipe_ctrl_pkg.sv
// Shared core definitions for the pipeline controller: hold encodings, bus widths and the
// helper that merges competing hold requests.
package pipe_ctrl_pkg;

   localparam int unsigned HoldFlagBus = 3;
   localparam int unsigned InstAddrBus = 32;

   typedef logic [HoldFlagBus-1:0] hold_t;

   localparam hold_t HoldNone = 3'b000;
   localparam hold_t HoldPc   = 3'b001;
   localparam hold_t HoldIf   = 3'b010;
   localparam hold_t HoldId   = 3'b011;

   localparam logic [InstAddrBus-1:0] ZeroWord = '0;

   // Hold levels are ordered, so merging two requests keeps the deeper one.
   function automatic hold_t hold_max(input hold_t a, input hold_t b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: passes ex-stage jumps to the PC, merges stall sources into one hold
// level and hands the core bus to an external master once the pipeline has drained.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   jump_req_i,
   input  logic [InstAddrBus-1:0] jump_addr_i,
   input  logic                   div_busy_i,
   input  logic                   bus_req_i,
   output logic [HoldFlagBus-1:0] hold_flag_o,
   output logic                   jump_flag_o,
   output logic [InstAddrBus-1:0] jump_addr_o,
   output logic                   bus_grant_o
);

   typedef enum logic [1:0] {
      StIdle,
      StFlush,
      StDrain,
      StOwn
   } state_e;

   localparam logic [3:0] CntLoad = 4'(DRAIN_CYCLES - 1);

   state_e     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       bus_grant_q;

   always_comb begin
      jump_flag_o = jump_req_i;
      jump_addr_o = jump_req_i ? jump_addr_i : ZeroWord;
   end

   always_comb begin
      hold_t hold;
      hold = HoldNone;
      if (jump_req_i)          hold = hold_max(hold, HoldId);
      if (div_busy_i)          hold = hold_max(hold, HoldId);
      if (state_q == StFlush)  hold = hold_max(hold, HoldId);
      if (state_q == StOwn)    hold = hold_max(hold, HoldId);
      if (state_q == StDrain)  hold = hold_max(hold, HoldPc);
      hold_flag_o = hold;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StIdle: begin
            if (jump_req_i) begin
               state_d = StFlush;
            end else if (bus_req_i) begin
               state_d = StDrain;
               cnt_d   = CntLoad;
            end
         end
         StFlush: begin
            if (bus_req_i) begin
               state_d = StDrain;
               cnt_d   = CntLoad;
            end else begin
               state_d = StIdle;
            end
         end
         StDrain: begin
            // A withdrawn request wins over everything; a jump restarts the drain window.
            if (!bus_req_i) begin
               state_d = StIdle;
            end else if (jump_req_i) begin
               cnt_d = CntLoad;
            end else if (!div_busy_i) begin
               if (cnt_q == 4'd0) begin
                  state_d = StOwn;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         StOwn: begin
            if (!bus_req_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         bus_grant_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bus_grant_q <= (state_d == StOwn);
      end
   end

   assign bus_grant_o = bus_grant_q;

endmodule
